msg_schedule: RTL and testbench
===============================

// Module: msg_schedule
// PURPOSE
//  SHA-256 message-schedule expander. Accepts one 512-bit block as 16 32-bit words
//  over a valid/ready input. Emits W[0..63] in order over a valid/ready output.
//  Sits between the block padder/loader and the compression round; it is the consumer
//  of the small-sigma cells (sigma0/sigma1).
//  Bit 0 of every word is the MSB ([0:31] ordering), as in the rest of the core.
// PARAMETERS
//  ROUNDS    64   number of schedule words emitted per block (>=16, <=64)
// PORTS
//  CLK        in   1   clock, all state on rising edge
//  RST_N      in   1   reset, asynchronous assert, active-low
//  IN_VALID   in   1   IN_WORD carries a message word
//  IN_READY   out  1   block accepts a word this cycle
//  IN_WORD    in   32  message word, big-endian, M[0] first
//  OUT_VALID  out  1   OUT_WORD holds W[OUT_IDX]
//  OUT_READY  in   1   downstream consumes OUT_WORD this cycle
//  OUT_WORD   out  32  schedule word W[t]
//  OUT_IDX    out  6   t, 0..ROUNDS-1
//  OUT_LAST   out  1   high with OUT_VALID when OUT_IDX==ROUNDS-1
// BEHAVIOUR
//  Clock/reset: one clock, CLK. Reset is RST_N, asynchronous and active-low.
//  Storage: 16x32 window w[0..15]; w[0] is always the word being offered.
//  State LOAD:
//   - IN_READY=1, OUT_VALID=0.
//   - Accept on IN_VALID&IN_READY: w[cnt]<=IN_WORD, cnt++.
//   - On the 16th accept go to EMIT; cnt<=0.
//  State EMIT:
//   - IN_READY=0; IN_VALID is ignored.
//   - OUT_VALID=1, OUT_WORD=w[0], OUT_IDX=cnt.
//   - On OUT_VALID&OUT_READY: shift w[i]<=w[i+1] and append w[15]<=nxt; cnt++.
//   - nxt = sigma1(w[14]) + w[9] + sigma0(w[1]) + w[0], all mod 2^32, carries dropped.
//   - sigma0(x) = ROTR7^ROTR18^SHR3; sigma1(x) = ROTR17^ROTR19^SHR10 (FIPS 180-4).
//   - Appends past W[ROUNDS-1] are computed and discarded; harmless.
//   - Handshake on OUT_IDX==ROUNDS-1: go to LOAD, cnt<=0. IN_READY=1 the next cycle.
//  Latency: 16th input accepted at edge k -> OUT_VALID=1, W[0] valid after edge k.
//  Throughput: 1 word/cycle each direction; min 16+ROUNDS cycles per block.
//  Backpressure: OUT_READY=0 holds OUT_WORD, OUT_IDX, OUT_LAST and window stable.
//   OUT_VALID never drops before its handshake.
//  IN_VALID=0 gaps in LOAD: no accept, cnt unchanged, no timeout.
//  Reset values:
//   - state=LOAD, cnt=0, window=0.
//   - OUT_VALID=0, OUT_WORD=0, OUT_IDX=0, OUT_LAST=0.
//   - IN_READY=1 (decoded from state); no handshake is taken while RST_N=0.
//  Reset mid-operation (LOAD or EMIT): block discarded immediately.
//   After release a fresh 16-word load is required.
//  Outputs are registered or decoded from registered state only; no comb path in->out.
// TESTING
//  T1 reset: RST_N=0 -> OUT_VALID=0, OUT_WORD=0, IN_READY=1.
//     Release, then 16 words -> first OUT_IDX=0.
//  T2 "abc" block:
//     - in 0x61626380, 14x 0x0, 0x00000018.
//     - W0..W15 = inputs; W16=0x61626380, W17=0x000F0000, W18=0x7DA86405.
//     - 64 words total, OUT_LAST only at idx 63.
//  T3 all-zero block -> 64 words all 0x00000000; then IN_READY=1 the cycle after idx 63.
//  T4 random OUT_READY (~50%) on "abc":
//     - word sequence identical to T2.
//     - OUT_WORD/OUT_IDX stable while stalled.
//     - IN_VALID pulses in EMIT are ignored.
//  T5 RST_N low at OUT_IDX=20:
//     - OUT_VALID=0 asynchronously.
//     - Reload all-zero block -> zeros from idx 0, no stale words.
//  T6 back-to-back blocks with IN_VALID=1 continuous:
//     - 16+64 cycles per block.
//     - Second block ("abc") output matches T2 and is unaffected by the first block.

Source files
------------

// File: rtl/msg_schedule.sv
// SHA-256 message-schedule expander: loads a 16-word block, then streams W[0..ROUNDS-1].
// Words are big-endian values; bit 31 here is the core's bit 0 (MSB).
module msg_schedule #(
  parameter int ROUNDS = 64
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] IN_WORD,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_WORD,
  output logic [5:0]  OUT_IDX,
  output logic        OUT_LAST
);

  localparam logic [0:0] S_LOAD   = 1'b0;
  localparam logic [0:0] S_EMIT   = 1'b1;
  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);
  localparam logic [5:0] LOAD_END = 6'd15;

  logic [0:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [31:0] nxt;
  logic        emit, in_acc, out_acc;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  assign emit    = (state_q == S_EMIT);
  assign in_acc  = !emit && IN_VALID;
  assign out_acc = emit && OUT_READY;

  // win_q[k] holds W[t+k]; the append computes W[t+16] from the current window.
  assign nxt = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    if (in_acc) begin
      win_d[cnt_q[3:0]] = IN_WORD;
      if (cnt_q == LOAD_END) begin
        state_d = S_EMIT;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
    end
    if (out_acc) begin
      for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
      win_d[15] = nxt;
      if (cnt_q == LAST_IDX) begin
        state_d = S_LOAD;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
    end
  end

  assign IN_READY  = !emit;
  assign OUT_VALID = emit;
  assign OUT_WORD  = win_q[0];
  assign OUT_IDX   = emit ? cnt_q : '0;
  assign OUT_LAST  = emit && (cnt_q == LAST_IDX);

endmodule

// File: tb/tb_msg_schedule.sv
// Directed bench for msg_schedule: "abc" and zero blocks, backpressure, mid-stream reset,
// and back-to-back streaming against an array-form schedule reference.
module tb_msg_schedule;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IN_WORD;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_WORD;
  logic [5:0]  OUT_IDX;
  logic        OUT_LAST;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] blk [16];
  logic [31:0] ew  [64];
  logic [31:0] got [64];
  logic [31:0] ew2 [128];
  logic [31:0] inw [32];

  msg_schedule #(.ROUNDS(64)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_WORD(IN_WORD),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_WORD(OUT_WORD),
    .OUT_IDX(OUT_IDX), .OUT_LAST(OUT_LAST)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  task automatic build_ref();
    for (int t = 0; t < 16; t++) ew[t] = blk[t];
    for (int t = 16; t < 64; t++)
      ew[t] = ref_s1(ew[t-2]) + ew[t-7] + ref_s0(ew[t-15]) + ew[t-16];
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    build_ref();
  endtask

  task automatic set_zero();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    build_ref();
  endtask

  task automatic load_block(input int gap_pct);
    int i = 0;
    int guard = 0;
    while (i < 16 && guard < 500) begin
      @(negedge CLK);
      guard++;
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        IN_VALID = 1'b0;
      end else begin
        IN_VALID = 1'b1;
        IN_WORD  = blk[i];
        check("in_ready_load", IN_READY, 1);
        i++;
      end
      @(posedge CLK);
    end
    #1 IN_VALID = 1'b0;
    if (guard >= 500) check("load_timeout", i, 16);
  endtask

  task automatic collect(input int rdy_pct, input bit poke_in);
    int idx = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [31:0] pw;
    logic [5:0]  pi;
    while (idx < 64 && cyc < 1000) begin
      @(negedge CLK);
      cyc++;
      if (stalled) begin
        check("stall_word", OUT_WORD, pw);
        check("stall_idx", OUT_IDX, pi);
      end
      if (poke_in) begin
        IN_VALID = 1'($urandom_range(1));
        IN_WORD  = $urandom;
      end
      OUT_READY = ($urandom_range(99) < rdy_pct);
      check("out_valid", OUT_VALID, 1);
      check("in_ready_emit", IN_READY, 0);
      if (OUT_READY) begin
        got[idx] = OUT_WORD;
        check($sformatf("w%0d", idx), OUT_WORD, ew[idx]);
        check($sformatf("idx%0d", idx), OUT_IDX, idx);
        check($sformatf("last%0d", idx), OUT_LAST, (idx == 63));
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        pw = OUT_WORD;
        pi = OUT_IDX;
      end
      @(posedge CLK);
    end
    #1;
    OUT_READY = 1'b0;
    IN_VALID  = 1'b0;
    if (cyc >= 1000) check("collect_timeout", idx, 64);
  endtask

  initial begin
    int in_p, out_p, cyc, first0, first1;
    bit acc;
    RST_N     = 1'b0;
    IN_VALID  = 1'b0;
    IN_WORD   = 32'h0;
    OUT_READY = 1'b0;

    // T1: reset values, then release and load
    repeat (2) @(negedge CLK);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_out_word", OUT_WORD, 0);
    check("rst_out_idx", OUT_IDX, 0);
    check("rst_out_last", OUT_LAST, 0);
    check("rst_in_ready", IN_READY, 1);
    RST_N = 1'b1;
    set_abc();
    load_block(0);
    check("lat_out_valid", OUT_VALID, 1);
    check("lat_out_idx", OUT_IDX, 0);

    // T2: "abc" block at full rate
    collect(100, 1'b0);
    check("abc_w16", got[16], 32'h61626380);
    check("abc_w17", got[17], 32'h000F0000);
    check("abc_w18", got[18], 32'h7DA86405);

    // T3: all-zero block, then back in LOAD
    set_zero();
    load_block(30);
    collect(100, 1'b0);
    @(negedge CLK);
    check("t3_in_ready_after", IN_READY, 1);
    check("t3_out_valid_after", OUT_VALID, 0);

    // T4: random backpressure with IN_VALID noise during EMIT
    set_abc();
    load_block(0);
    collect(50, 1'b1);

    // T5: reset at idx 20, then zero block must come out clean
    set_abc();
    load_block(0);
    OUT_READY = 1'b1;
    repeat (20) @(posedge CLK);
    #1 OUT_READY = 1'b0;
    @(negedge CLK);
    check("t5_pre_idx", OUT_IDX, 20);
    check("t5_pre_valid", OUT_VALID, 1);
    #2 RST_N = 1'b0;
    #1;
    check("t5_async_valid", OUT_VALID, 0);
    check("t5_async_word", OUT_WORD, 0);
    check("t5_async_idx", OUT_IDX, 0);
    check("t5_async_in_ready", IN_READY, 1);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    set_zero();
    load_block(0);
    collect(100, 1'b0);

    // T6: two blocks streamed with IN_VALID held high
    for (int i = 0; i < 16; i++) blk[i] = 32'h01020304 * (i + 1) ^ 32'hA5A50000;
    build_ref();
    for (int i = 0; i < 16; i++) inw[i] = blk[i];
    for (int i = 0; i < 64; i++) ew2[i] = ew[i];
    set_abc();
    for (int i = 0; i < 16; i++) inw[16+i] = blk[i];
    for (int i = 0; i < 64; i++) ew2[64+i] = ew[i];
    in_p = 0; out_p = 0; cyc = 0; first0 = -1; first1 = -1;
    OUT_READY = 1'b1;
    while (out_p < 128 && cyc < 400) begin
      @(negedge CLK);
      IN_VALID = (in_p < 32);
      IN_WORD  = (in_p < 32) ? inw[in_p] : 32'h0;
      acc = IN_READY && IN_VALID;
      if (OUT_VALID) begin
        if (out_p == 0)  first0 = cyc;
        if (out_p == 64) first1 = cyc;
        check($sformatf("b2b_w%0d", out_p), OUT_WORD, ew2[out_p]);
        check($sformatf("b2b_idx%0d", out_p), OUT_IDX, out_p % 64);
        check($sformatf("b2b_last%0d", out_p), OUT_LAST, (out_p % 64 == 63));
        out_p++;
      end
      @(posedge CLK);
      if (acc) in_p++;
      cyc++;
    end
    #1;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
    check("b2b_words", out_p, 128);
    check("b2b_latency", first0, 16);
    check("b2b_period", first1 - first0, 80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
